// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Shares one single-port data RAM between the processor load/store port and a
// button-driven inspection (view) port. The view port only reads: the buttons
// step view_addr and the block re-reads that word so it can be displayed.
//
// CPU handshake: cpu_req is raised together with cpu_we/cpu_addr/cpu_wdata and
// all four are held unchanged until cpu_ack. cpu_ack is a one-cycle pulse that
// marks completion; on a read, cpu_rdata is valid in that cycle and keeps its
// value until the next read completes. A requester that keeps cpu_req high
// after the ack cycle is seen as issuing a new access.
module ram_access_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int DEB_CYCLES = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [2:0]        btn,
  output logic [ADDR_W-1:0] view_addr,
  output logic [DATA_W-1:0] view_data,
  output logic              view_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  output logic [2:0]        state_dbg
);

  localparam int CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CPU_ISSUE  = 3'd1,
    CPU_WAIT   = 3'd2,
    VIEW_ISSUE = 3'd3,
    VIEW_WAIT  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic                grant_cpu;
  logic                grant_view;
  logic                view_pending;
  logic [STARVE_W-1:0] starve_cnt;

  // Button path: sync1/sync2 synchronize the raw active-low levels; pressed
  // holds the debounced level (1 = accepted as pressed).
  logic [2:0]            sync1;
  logic [2:0]            sync2;
  logic [2:0]            pressed;
  logic [2:0][CNT_W-1:0] deb_cnt;
  logic [2:0]            differs;
  logic [2:0]            at_limit;
  logic [2:0]            press_evt;
  logic                  evt;
  logic [ADDR_W-1:0]     addr_next;

  assign state_dbg = state;

  // Two-stage synchronizer; idles high so reset never looks like a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A sample "differs" when the synchronized level disagrees with the
  // accepted level; the DEB_CYCLES-th consecutive differing sample flips it.
  always_comb begin
    differs   = '0;
    at_limit  = '0;
    press_evt = '0;
    for (int i = 0; i < 3; i++) begin
      differs[i]   = (~sync2[i]) != pressed[i];
      at_limit[i]  = deb_cnt[i] == CNT_W'(DEB_CYCLES - 1);
      press_evt[i] = differs[i] && at_limit[i] && !pressed[i];
    end
  end

  // Debounce counters: count consecutive differing samples, restart on any
  // agreeing sample, flip the accepted level when the run is long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressed <= '0;
      deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!differs[i]) begin
          deb_cnt[i] <= '0;
        end else if (at_limit[i]) begin
          deb_cnt[i] <= '0;
          pressed[i] <= ~pressed[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pick one event per cycle (clear > increment > decrement); events that
  // lose arbitration in the same cycle are dropped.
  always_comb begin
    evt       = |press_evt;
    addr_next = view_addr;
    if (press_evt[2]) begin
      addr_next = '0;
    end else if (press_evt[0]) begin
      addr_next = view_addr + ADDR_W'(1);
    end else if (press_evt[1]) begin
      addr_next = view_addr - ADDR_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant decision. In the cycle cpu_ack is high the still
  // asserted cpu_req belongs to the finished access, so IDLE makes no grant
  // at all; this keeps a continuously requesting CPU from being handed the
  // view slot early and makes the starvation bound count whole accesses.
  always_comb begin
    state_next = state;
    grant_cpu  = 1'b0;
    grant_view = 1'b0;
    case (state)
      IDLE: begin
        if (!cpu_ack) begin
          if (cpu_req && (!view_pending || starve_cnt < STARVE_W'(STARVE_MAX))) begin
            grant_cpu  = 1'b1;
            state_next = CPU_ISSUE;
          end else if (view_pending) begin
            grant_view = 1'b1;
            state_next = VIEW_ISSUE;
          end
        end
      end
      // ram_we still carries the granted cpu_we during CPU_ISSUE.
      CPU_ISSUE:  state_next = ram_we ? IDLE : CPU_WAIT;
      CPU_WAIT:   state_next = IDLE;
      VIEW_ISSUE: state_next = VIEW_WAIT;
      VIEW_WAIT:  state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // Datapath: RAM port registers, CPU completion, view result and the view
  // address. Button events are applied last so they win over a view grant or
  // completion on the same edge (the read in flight used the old address).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      view_addr    <= '0;
      view_data    <= '0;
      view_valid   <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      view_pending <= 1'b1;
      starve_cnt   <= '0;
    end else begin
      cpu_ack <= 1'b0;
      if (grant_cpu) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_we    <= cpu_we;
        if (view_pending) begin
          starve_cnt <= starve_cnt + STARVE_W'(1);
        end
      end else if (grant_view) begin
        ram_addr     <= view_addr;
        ram_we       <= 1'b0;
        view_pending <= 1'b0;
        starve_cnt   <= '0;
      end
      case (state)
        CPU_ISSUE: begin
          ram_we <= 1'b0;
          if (ram_we) begin
            cpu_ack <= 1'b1;
          end
        end
        CPU_WAIT: begin
          cpu_rdata <= ram_q;
          cpu_ack   <= 1'b1;
        end
        VIEW_WAIT: begin
          view_data <= ram_q;
          if (!view_pending) begin
            view_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      if (evt) begin
        view_addr    <= addr_next;
        view_pending <= 1'b1;
        view_valid   <= 1'b0;
      end
    end
  end

endmodule
